// File: rtl/mem_sp_req_ctrl.sv
// mem_sp_req_ctrl
//
// Request-side controller for a single-port SRAM macro (mem_sp_sky130). It is
// the only agent driving the macro port. Read/write requests arrive on a
// valid/ready channel and are issued at up to one per cycle. Reads are tracked
// through the fixed macro read latency and their data is returned, in request
// order, on a backpressurable first-word-fall-through response channel. After
// reset the array can optionally be swept to a constant value.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_vld/req_rdy            request handshake (accept on vld && rdy)
//   req_we, req_addr,
//   req_wdata, req_bwe         request payload (1 = write, 0 = read)
//   rsp_vld/rsp_rdy, rsp_data  read response channel (pop on vld && rdy)
//   mem_addr, mem_wen, mem_ren,
//   mem_wdata, mem_bwe         registered drive into the SRAM macro
//   mem_rdata                  read data from the SRAM macro
//   init_done                  high once the controller accepts requests
module mem_sp_req_ctrl #(
   parameter int                  DATA_BIT  = 32,
   parameter int                  DEPTH     = 128,
   parameter int                  ADDR_BIT  = $clog2(DEPTH),
   parameter int                  RD_LAT    = 2,
   parameter int                  RSP_DEPTH = 4,
   parameter int                  INIT_EN   = 1,
   parameter logic [DATA_BIT-1:0] INIT_VAL  = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_vld,
   output logic                req_rdy,
   input  logic                req_we,
   input  logic [ADDR_BIT-1:0] req_addr,
   input  logic [DATA_BIT-1:0] req_wdata,
   input  logic [DATA_BIT-1:0] req_bwe,
   output logic                rsp_vld,
   input  logic                rsp_rdy,
   output logic [DATA_BIT-1:0] rsp_data,
   output logic [ADDR_BIT-1:0] mem_addr,
   output logic                mem_wen,
   output logic                mem_ren,
   output logic [DATA_BIT-1:0] mem_wdata,
   output logic [DATA_BIT-1:0] mem_bwe,
   input  logic [DATA_BIT-1:0] mem_rdata,
   output logic                init_done
);

   localparam int CNT_BIT = $clog2(RSP_DEPTH + 1);
   localparam int PTR_BIT = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   // Wide enough for FIFO count plus every pipe bit, even though the credit
   // rule keeps the sum at or below RSP_DEPTH.
   localparam int OCC_BIT = $clog2(RSP_DEPTH + RD_LAT + 2);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_BIT-1:0] icnt_q, icnt_d;
   logic                init_wr_done_q, init_wr_done_d;

   logic [ADDR_BIT-1:0] mem_addr_q, mem_addr_d;
   logic                mem_wen_q, mem_wen_d;
   logic                mem_ren_q, mem_ren_d;
   logic [DATA_BIT-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_BIT-1:0] mem_bwe_q, mem_bwe_d;

   logic [RD_LAT:0]     rd_pipe_q, rd_pipe_d;
   logic                rd_issue;

   logic [DATA_BIT-1:0] fifo_q [RSP_DEPTH];
   logic [DATA_BIT-1:0] fifo_d [RSP_DEPTH];
   logic [PTR_BIT-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_BIT-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_BIT-1:0]  fifo_cnt_q, fifo_cnt_d;

   logic [OCC_BIT-1:0]  inflight;
   logic [OCC_BIT-1:0]  occ;
   logic                push;
   logic                pop;
   logic                fifo_full;

   // Pointer advance with explicit wrap so RSP_DEPTH need not be a power of two.
   function automatic logic [PTR_BIT-1:0] ptr_inc(input logic [PTR_BIT-1:0] p);
      if (p == PTR_BIT'(RSP_DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // Occupancy: reads still travelling through the macro plus queued responses.
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= RD_LAT; i++) begin
         inflight = inflight + OCC_BIT'(rd_pipe_q[i]);
      end
      occ = inflight + OCC_BIT'(fifo_cnt_q);
   end

   // FSM, credit check and macro drive
   always_comb begin
      state_d        = state_q;
      icnt_d         = icnt_q;
      init_wr_done_d = init_wr_done_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      mem_bwe_d      = mem_bwe_q;
      mem_wen_d      = 1'b0;
      mem_ren_d      = 1'b0;
      rd_issue       = 1'b0;
      req_rdy        = 1'b0;

      case (state_q)
         ST_INIT: begin
            if (INIT_EN == 0) begin
               state_d = ST_RUN;
            end else if (init_wr_done_q) begin
               // The last sweep write is on the macro port this cycle.
               state_d = ST_RUN;
            end else begin
               mem_wen_d   = 1'b1;
               mem_addr_d  = icnt_q;
               mem_wdata_d = INIT_VAL;
               mem_bwe_d   = '1;
               if (icnt_q == ADDR_BIT'(DEPTH - 1)) begin
                  init_wr_done_d = 1'b1;
               end else begin
                  icnt_d = icnt_q + 1'b1;
               end
            end
         end
         ST_RUN: begin
            // Writes are gated by the same credit so issue order stays simple.
            req_rdy = (occ < OCC_BIT'(RSP_DEPTH));
            if (req_vld && req_rdy) begin
               mem_addr_d  = req_addr;
               mem_wdata_d = req_wdata;
               mem_bwe_d   = req_bwe;
               mem_wen_d   = req_we;
               mem_ren_d   = !req_we;
               rd_issue    = !req_we;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Read-valid pipe and response FIFO
   always_comb begin
      rd_pipe_d[0] = rd_issue;
      for (int i = 1; i <= RD_LAT; i++) begin
         rd_pipe_d[i] = rd_pipe_q[i-1];
      end

      push      = rd_pipe_q[RD_LAT];
      pop       = rsp_vld && rsp_rdy;
      fifo_full = (fifo_cnt_q == CNT_BIT'(RSP_DEPTH));

      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;

      // When full, push and pop share a slot: the head is consumed this cycle
      // and its slot is refilled at the same edge.
      if (push) begin
         fifo_d[wr_ptr_q] = mem_rdata;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
         fifo_cnt_d = fifo_cnt_q + 1'b1;
      end else if (!push && pop) begin
         fifo_cnt_d = fifo_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_INIT;
         icnt_q         <= '0;
         init_wr_done_q <= 1'b0;
         mem_addr_q     <= '0;
         mem_wen_q      <= 1'b0;
         mem_ren_q      <= 1'b0;
         mem_wdata_q    <= '0;
         mem_bwe_q      <= '0;
         rd_pipe_q      <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         fifo_cnt_q     <= '0;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q        <= state_d;
         icnt_q         <= icnt_d;
         init_wr_done_q <= init_wr_done_d;
         mem_addr_q     <= mem_addr_d;
         mem_wen_q      <= mem_wen_d;
         mem_ren_q      <= mem_ren_d;
         mem_wdata_q    <= mem_wdata_d;
         mem_bwe_q      <= mem_bwe_d;
         rd_pipe_q      <= rd_pipe_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         fifo_cnt_q     <= fifo_cnt_d;
         fifo_q         <= fifo_d;
      end
   end

   assign rsp_vld   = (fifo_cnt_q != '0);
   assign rsp_data  = fifo_q[rd_ptr_q];
   assign mem_addr  = mem_addr_q;
   assign mem_wen   = mem_wen_q;
   assign mem_ren   = mem_ren_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_bwe   = mem_bwe_q;
   assign init_done = (state_q == ST_RUN);

   // The credit rule makes overflow impossible; a push into a full FIFO
   // without a matching pop means the occupancy accounting is broken.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && fifo_full && !pop));

endmodule

// File: tb/tb_mem_sp_req_ctrl.sv
module tb_mem_sp_req_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance: DEPTH=128, init sweep enabled
   logic        rst_n;
   logic        req_vld, req_rdy, req_we;
   logic [6:0]  req_addr;
   logic [31:0] req_wdata, req_bwe;
   logic        rsp_vld, rsp_rdy;
   logic [31:0] rsp_data;
   logic [6:0]  mem_addr;
   logic        mem_wen, mem_ren;
   logic [31:0] mem_wdata, mem_bwe, mem_rdata;
   logic        init_done;

   mem_sp_req_ctrl #(.DATA_BIT(32), .DEPTH(128), .RD_LAT(2), .RSP_DEPTH(4),
                     .INIT_EN(1), .INIT_VAL(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_bwe(req_bwe),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren),
      .mem_wdata(mem_wdata), .mem_bwe(mem_bwe), .mem_rdata(mem_rdata),
      .init_done(init_done));

   // Second instance: DEPTH=100, no init sweep
   logic        b_rst_n;
   logic        b_req_vld, b_req_rdy, b_req_we;
   logic [6:0]  b_req_addr;
   logic [31:0] b_req_wdata, b_req_bwe;
   logic        b_rsp_vld, b_rsp_rdy;
   logic [31:0] b_rsp_data;
   logic [6:0]  b_mem_addr;
   logic        b_mem_wen, b_mem_ren;
   logic [31:0] b_mem_wdata, b_mem_bwe, b_mem_rdata;
   logic        b_init_done;

   mem_sp_req_ctrl #(.DATA_BIT(32), .DEPTH(100), .RD_LAT(2), .RSP_DEPTH(4),
                     .INIT_EN(0), .INIT_VAL(32'h0)) dut_b (
      .clk(clk), .rst_n(b_rst_n),
      .req_vld(b_req_vld), .req_rdy(b_req_rdy), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_bwe(b_req_bwe),
      .rsp_vld(b_rsp_vld), .rsp_rdy(b_rsp_rdy), .rsp_data(b_rsp_data),
      .mem_addr(b_mem_addr), .mem_wen(b_mem_wen), .mem_ren(b_mem_ren),
      .mem_wdata(b_mem_wdata), .mem_bwe(b_mem_bwe), .mem_rdata(b_mem_rdata),
      .init_done(b_init_done));

   // SRAM macro models: sample at the edge, data valid two edges later
   logic [31:0] sram_a [128];
   logic [31:0] a_s0, a_s1;
   always @(posedge clk) begin
      if (mem_wen) sram_a[mem_addr] <= (sram_a[mem_addr] & ~mem_bwe) | (mem_wdata & mem_bwe);
      a_s0 <= sram_a[mem_addr];
      a_s1 <= a_s0;
   end
   assign mem_rdata = a_s1;

   logic [31:0] sram_b [100];
   logic [31:0] b_s0, b_s1;
   always @(posedge clk) begin
      if (b_mem_wen) sram_b[b_mem_addr] <= (sram_b[b_mem_addr] & ~b_mem_bwe) | (b_mem_wdata & b_mem_bwe);
      b_s0 <= sram_b[b_mem_addr];
      b_s1 <= b_s0;
   end
   assign b_mem_rdata = b_s1;

   int          n_chk = 0;
   int          n_pass = 0;
   logic        last_acc;
   logic [31:0] got_q [$];
   logic [31:0] exp_q [$];
   logic [31:0] exp_mem [128];

   typedef struct {
      logic        we;
      logic [6:0]  addr;
      logic [31:0] wdata;
      logic [31:0] bwe;
      logic [31:0] exp_rd;
   } vec_t;
   vec_t vec [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // One clock: record handshakes as seen just before the edge.
   task automatic step();
      logic        a, p;
      logic [31:0] d;
      a = req_vld && req_rdy;
      p = rsp_vld && rsp_rdy;
      d = rsp_data;
      @(posedge clk); #1;
      last_acc = a;
      if (p) got_q.push_back(d);
   endtask

   task automatic issue(input logic we, input logic [6:0] addr, input logic [31:0] wd,
                        input logic [31:0] be, output logic ok);
      req_we = we; req_addr = addr; req_wdata = wd; req_bwe = be; req_vld = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         step();
         ok = last_acc;
      end
      req_vld = 1'b0;
   endtask

   task automatic wait_rsp(output logic ok);
      for (int i = 0; i < 40 && got_q.size() == 0; i++) step();
      ok = (got_q.size() != 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctrl"}, 64'({req_rdy, rsp_vld, mem_wen, mem_ren, init_done, mem_addr}), 64'd0);
      check({tag, "_data"}, {rsp_data, mem_wdata}, 64'd0);
      check({tag, "_bwe"}, 64'(mem_bwe), 64'd0);
   endtask

   // Called right after rst_n is released (1 time unit past an edge).
   task automatic init_check(input string tag);
      int good;
      good = 0;
      for (int k = 0; k < 128; k++) begin
         @(posedge clk); #1;
         if (mem_wen === 1'b1 && mem_ren === 1'b0 && mem_addr === 7'(k) &&
             mem_wdata === 32'h0 && mem_bwe === 32'hFFFF_FFFF &&
             init_done === 1'b0 && req_rdy === 1'b0 && rsp_vld === 1'b0)
            good++;
      end
      check({tag, "_sweep"}, 64'(good), 64'd128);
      @(posedge clk); #1;
      check({tag, "_done"}, 64'({init_done, req_rdy, mem_wen}), 64'(3'b110));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      int   idx, n, cyc, errs, norrdy, lat;
      logic [6:0]  cur;
      logic [31:0] d;
      logic [2:0]  pat;

      vec[0]  = '{1'b0, 7'd0,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      vec[1]  = '{1'b0, 7'd127, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      vec[2]  = '{1'b1, 7'd10,  32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000};
      vec[3]  = '{1'b0, 7'd10,  32'h0000_0000, 32'h0000_0000, 32'h1234_5678};
      vec[4]  = '{1'b1, 7'd10,  32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_0000};
      vec[5]  = '{1'b0, 7'd10,  32'h0000_0000, 32'h0000_0000, 32'h1234_FFFF};
      vec[6]  = '{1'b1, 7'd127, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'h0000_0000};
      vec[7]  = '{1'b0, 7'd127, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D};
      vec[8]  = '{1'b1, 7'd0,   32'h00FF_00FF, 32'hFF00_FF00, 32'h0000_0000};
      vec[9]  = '{1'b0, 7'd0,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      vec[10] = '{1'b1, 7'd0,   32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h0000_0000};
      vec[11] = '{1'b0, 7'd0,   32'h0000_0000, 32'h0000_0000, 32'h0505_0505};

      rst_n = 1'b0; req_vld = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_bwe = '0; rsp_rdy = 1'b0;
      b_rst_n = 1'b0; b_req_vld = 1'b0; b_req_we = 1'b0; b_req_addr = '0;
      b_req_wdata = '0; b_req_bwe = '0; b_rsp_rdy = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      init_check("init");

      // Table-driven reads/writes, one at a time
      rsp_rdy = 1'b1;
      got_q.delete();
      for (int i = 0; i < 12; i++) begin
         issue(vec[i].we, vec[i].addr, vec[i].wdata, vec[i].bwe, ok);
         check($sformatf("vec%0d_issue", i), 64'(ok), 64'd1);
         if (vec[i].we) begin
            check($sformatf("vec%0d_wr_ctl", i), 64'({mem_wen, mem_ren, mem_addr}), 64'({1'b1, 1'b0, vec[i].addr}));
            check($sformatf("vec%0d_wr_data", i), {mem_wdata, mem_bwe}, {vec[i].wdata, vec[i].bwe});
         end else begin
            check($sformatf("vec%0d_rd_ctl", i), 64'({mem_wen, mem_ren, mem_addr}), 64'({1'b0, 1'b1, vec[i].addr}));
            wait_rsp(ok);
            check($sformatf("vec%0d_rsp_seen", i), 64'(ok), 64'd1);
            if (ok) begin
               d = got_q.pop_front();
               check($sformatf("vec%0d_rdata", i), 64'(d), 64'(vec[i].exp_rd));
            end
         end
      end

      // Back-to-back write then read of the same address
      got_q.delete();
      req_vld = 1'b1; req_we = 1'b1; req_addr = 7'd5; req_wdata = 32'hDEAD_BEEF; req_bwe = '1;
      check("b2b_rdy_wr", 64'(req_rdy), 64'd1);
      step();
      check("b2b_acc_wr", 64'(last_acc), 64'd1);
      req_we = 1'b0;
      check("b2b_rdy_rd", 64'(req_rdy), 64'd1);
      step();
      check("b2b_acc_rd", 64'(last_acc), 64'd1);
      check("b2b_rd_drive", 64'({mem_wen, mem_ren, mem_addr}), 64'({1'b0, 1'b1, 7'd5}));
      req_vld = 1'b0;
      pat = '0;
      for (int k = 0; k < 3; k++) begin
         step();
         pat = {pat[1:0], rsp_vld};
      end
      check("b2b_rsp_latency", 64'(pat), 64'(3'b001));
      check("b2b_rdata", 64'(rsp_data), 64'hDEAD_BEEF);
      step();
      got_q.delete();

      // Backpressure: prefill 20..27, then offer 8 reads with rsp_rdy low
      for (int i = 0; i < 8; i++) begin
         issue(1'b1, 7'(20 + i), 32'hA000_0000 + 32'(i), '1, ok);
         check($sformatf("bp_fill%0d", i), 64'(ok), 64'd1);
      end
      rsp_rdy = 1'b0;
      got_q.delete();
      idx = 0;
      req_vld = 1'b1; req_we = 1'b0;
      for (int c = 0; c < 4; c++) begin
         req_addr = 7'(20 + idx);
         step();
         if (last_acc) idx++;
      end
      check("bp_acc_first4", 64'(idx), 64'd4);
      check("bp_rdy_low", 64'(req_rdy), 64'd0);
      for (int c = 0; c < 8; c++) begin
         req_addr = 7'(20 + idx);
         step();
         if (last_acc) idx++;
      end
      check("bp_acc_held", 64'(idx), 64'd4);
      check("bp_rsp_vld", 64'(rsp_vld), 64'd1);
      check("bp_head", 64'(rsp_data), 64'hA000_0000);
      check("bp_no_pop", 64'(got_q.size()), 64'd0);
      rsp_rdy = 1'b1;
      for (int c = 0; c < 40 && idx < 8; c++) begin
         req_addr = 7'(20 + idx);
         step();
         if (last_acc) idx++;
      end
      req_vld = 1'b0;
      for (int c = 0; c < 40 && got_q.size() < 8; c++) step();
      check("bp_total_acc", 64'(idx), 64'd8);
      check("bp_rsp_count", 64'(got_q.size()), 64'd8);
      errs = 0;
      for (int i = 0; i < got_q.size(); i++)
         if (got_q[i] !== 32'hA000_0000 + 32'(i)) errs++;
      check("bp_order", 64'(errs), 64'd0);

      // Streaming: random prefill, then 64 random reads with rsp_rdy high
      for (int a = 0; a < 128; a++) begin
         d = $urandom();
         exp_mem[a] = d;
         issue(1'b1, 7'(a), d, '1, ok);
         if (!ok) check("stream_fill", 64'(ok), 64'd1);
      end
      got_q.delete();
      exp_q.delete();
      n = 0; cyc = 0; norrdy = 0;
      cur = 7'($urandom_range(0, 127));
      req_vld = 1'b1; req_we = 1'b0;
      while (n < 64 && cyc < 1000) begin
         req_addr = cur;
         if (!req_rdy) norrdy++;
         step();
         cyc++;
         if (last_acc) begin
            exp_q.push_back(exp_mem[cur]);
            n++;
            cur = 7'($urandom_range(0, 127));
         end
      end
      req_vld = 1'b0;
      for (int c = 0; c < 40 && got_q.size() < 64; c++) step();
      check("stream_acc", 64'(n), 64'd64);
      check("stream_rsp_count", 64'(got_q.size()), 64'd64);
      check("stream_credit_full", 64'(norrdy > 0), 64'd1);
      errs = 0;
      for (int i = 0; i < 64 && i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) errs++;
      check("stream_scoreboard", 64'(errs), 64'd0);

      // Mid-operation reset: 2 entries in FIFO, 2 reads in flight
      rsp_rdy = 1'b0;
      got_q.delete();
      idx = 0;
      req_vld = 1'b1; req_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
         req_addr = 7'(40 + k);
         step();
         if (last_acc) idx++;
      end
      req_vld = 1'b0;
      step();
      check("mrst_acc", 64'(idx), 64'd4);
      check("mrst_vld_before", 64'(rsp_vld), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mrst_immediate");
      @(posedge clk); @(posedge clk); #1;
      check_reset_outputs("mrst_held");
      rst_n = 1'b1;
      rsp_rdy = 1'b1;
      init_check("reinit");
      check("reinit_no_stale", 64'(rsp_vld), 64'd0);
      issue(1'b0, 7'd40, '0, '0, ok);
      wait_rsp(ok);
      check("reinit_rsp_seen", 64'(ok), 64'd1);
      if (ok) begin
         d = got_q.pop_front();
         check("reinit_rdata", 64'(d), 64'd0);
      end

      // INIT_EN=0, DEPTH=100 instance
      @(posedge clk); #1;
      check("b_reset", 64'({b_req_rdy, b_rsp_vld, b_init_done, b_mem_wen, b_mem_ren}), 64'd0);
      b_rst_n = 1'b1;
      check("b_rdy_before_edge", 64'(b_req_rdy), 64'd0);
      @(posedge clk); #1;
      check("b_run_edge1", 64'({b_req_rdy, b_init_done, b_mem_wen}), 64'(3'b110));
      b_req_vld = 1'b1; b_req_we = 1'b1; b_req_addr = 7'd99;
      b_req_wdata = 32'h0BAD_F00D; b_req_bwe = '1;
      @(posedge clk); #1;
      check("b_wr_drive", 64'({b_mem_wen, b_mem_ren, b_mem_addr}), 64'({1'b1, 1'b0, 7'd99}));
      b_req_we = 1'b0;
      check("b_rdy_rd", 64'(b_req_rdy), 64'd1);
      @(posedge clk); #1;
      check("b_rd_drive", 64'({b_mem_wen, b_mem_ren, b_mem_addr}), 64'({1'b0, 1'b1, 7'd99}));
      b_req_vld = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
         @(posedge clk); #1;
         if (b_rsp_vld) lat = k;
      end
      check("b_rsp_latency", 64'(lat), 64'd3);
      check("b_rdata", 64'(b_rsp_data), 64'h0BAD_F00D);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
